pid_compensator: RTL

//  Incremental (velocity-form) PID compensator for the buck loop. Takes one ADC sample per

---
 rtl/pid_compensator_if.sv | 20 ++
 rtl/pid_compensator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pid_compensator_if.sv
// ADC-sample in / duty-command out bundle of the buck-loop PID compensator.
interface pid_compensator_if;
    logic [7:0] vref;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic [8:0] d_n_out;
    logic       d_valid;
    logic       busy;
    logic       overrun;

    modport master (
        output vref, adc_data, adc_valid,
        input  d_n_out, d_valid, busy, overrun
    );

    modport slave (
        input  vref, adc_data, adc_valid,
        output d_n_out, d_valid, busy, overrun
    );
endinterface

// File: rtl/pid_compensator.sv
// Velocity-form PID for the buck loop: one shared multiplier, IDLE/MA/MB/MC/SAT FSM.
// Optional soft-start duty ramp: define COMP_SOFTSTART_EN.
module pid_compensator #(
`ifdef COMP_SOFTSTART_EN
    parameter int SS_STEP = 4,
`endif
    parameter int COEF_W = 10,
    parameter int FRAC   = 6,
    parameter int ACC_W  = 24,
    parameter int KA     = 64,
    parameter int KB     = -96,
    parameter int KC     = 40,
    parameter int DMIN   = 0,
    parameter int DMAX   = 460
) (
    input logic              clk,
    input logic              rst,
    pid_compensator_if.slave bus
);

    localparam int PW = COEF_W + 9;
    localparam int YW = ACC_W - FRAC;
    localparam logic signed [YW-1:0] P_MIN = YW'(DMIN);

    typedef enum logic [2:0] {
        S_IDLE, S_MA, S_MB, S_MC, S_SAT
    } state_t;

    state_t                   r_state;
    logic signed [8:0]        r_e0, r_e1, r_e2;
    logic signed [ACC_W-1:0]  r_acc;
    logic [8:0]               r_dout;
    logic                     r_dvalid;
    logic                     r_busy;
    logic                     r_overrun;

    logic signed [8:0]        w_e_new;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [8:0]        w_err;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [YW-1:0]     w_y;
    logic signed [YW-1:0]     w_lim_s;
    logic [8:0]               w_lim;
    logic [8:0]               w_clamp;
    logic                     w_accept;

    assign w_e_new  = $signed({1'b0, bus.vref}) - $signed({1'b0, bus.adc_data});
    assign w_accept = bus.adc_valid && (r_state == S_IDLE);

    always_comb begin
        w_coef = '0;
        w_err  = '0;
        case (r_state)
            S_MA:    begin w_coef = COEF_W'(KA); w_err = r_e0; end
            S_MB:    begin w_coef = COEF_W'(KB); w_err = r_e1; end
            S_MC:    begin w_coef = COEF_W'(KC); w_err = r_e2; end
            default: begin w_coef = '0;          w_err = '0;   end
        endcase
    end

    assign w_prod     = w_coef * w_err;
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_y        = r_acc[ACC_W-1:FRAC];
    assign w_lim_s    = {{(YW-9){1'b0}}, w_lim};

    always_comb begin
        w_clamp = w_y[8:0];
        if (w_y < P_MIN)
            w_clamp = 9'(DMIN);
        else if (w_y > w_lim_s)
            w_clamp = w_lim;
    end

`ifdef COMP_SOFTSTART_EN
    localparam int SSW = (SS_STEP > 1) ? $clog2(SS_STEP) : 1;

    logic [8:0]     r_lim;
    logic [SSW-1:0] r_ss_cnt;

    // Limit ramps one LSB per SS_STEP accepted samples, counted at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lim    <= 9'(DMIN);
            r_ss_cnt <= '0;
        end else if (w_accept) begin
            if (r_ss_cnt == SSW'(SS_STEP - 1)) begin
                r_ss_cnt <= '0;
                if (r_lim < 9'(DMAX))
                    r_lim <= r_lim + 9'd1;
            end else begin
                r_ss_cnt <= r_ss_cnt + SSW'(1);
            end
        end
    end

    assign w_lim = r_lim;
`else
    assign w_lim = 9'(DMAX);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_e0      <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            r_acc     <= '0;
            r_dout    <= '0;
            r_dvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            if (bus.adc_valid && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_e0    <= w_e_new;
                        r_busy  <= 1'b1;
                        r_state <= S_MA;
                    end
                end
                S_MA: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_MB;
                end
                S_MB: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_MC;
                end
                S_MC: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_SAT;
                end
                S_SAT: begin
                    // Writing back the clamped value is the anti-windup.
                    r_acc    <= {{(ACC_W-9-FRAC){1'b0}}, w_clamp, {FRAC{1'b0}}};
                    r_e2     <= r_e1;
                    r_e1     <= r_e0;
                    r_dout   <= w_clamp;
                    r_dvalid <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.d_n_out = r_dout;
    assign bus.d_valid = r_dvalid;
    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;

endmodule
